// File: rtl/ir_hdng_fuse.sv
// ir_hdng_fuse: filtered IR wall-following error with P+D correction of desired heading.
// Stage 1 updates the moving-average and derivative state on vld; stage 2 registers the clipped output.
module ir_hdng_fuse #(
    parameter logic [11:0] NOM_IR   = 12'h970,
    parameter int          AVG_LOG  = 2,
    parameter int          P_SHFT   = 5,
    parameter int          D_PERIOD = 4,
    parameter int          D_SHFT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic [11:0] lft_IR,
    input  logic [11:0] rght_IR,
    input  logic        en_fusion,
    input  logic [11:0] dsrd_hdng,
    output logic [11:0] dsrd_hdng_adj,
    output logic        adj_vld,
    output logic        sat
);
    localparam int DEPTH = 1 << AVG_LOG;
    localparam int PW    = (AVG_LOG > 0) ? AVG_LOG : 1;
    localparam int SW    = 12 + AVG_LOG;
    localparam int DW    = 9 + D_SHFT;

    logic signed [11:0]   buf_q [DEPTH];
    logic [PW-1:0]        ptr;
    logic signed [SW-1:0] sum;
    logic [7:0]           cnt;
    logic signed [11:0]   snap;
    logic                 primed;
    logic signed [DW-1:0] dterm;
    logic [1:0]           opn_q;
    logic                 s1_vld;

    logic signed [12:0]   lw, rw, nw, err_raw, diff;
    logic signed [11:0]   err, old, avg_nxt, avg_q, p_term;
    logic signed [SW-1:0] sum_nxt, sum_fl;
    logic signed [8:0]    d9;
    logic signed [DW-1:0] dterm_nxt;
    logic signed [12:0]   csum, corr;
    logic signed [13:0]   s14;
    logic signed [11:0]   clip;
    logic                 clipped, flush, evt;
    logic [7:0]           cnt_inc;
    logic [PW-1:0]        ptr_nxt;

    assign lw = $signed({1'b0, lft_IR});
    assign rw = $signed({1'b0, rght_IR});
    assign nw = $signed({1'b0, NOM_IR});

    always_comb begin
        err_raw   = (lft_opn && rght_opn) ? 13'sd0 :
                    lft_opn               ? nw - rw :
                    rght_opn              ? lw - nw :
                                            (lw - rw) >>> 1;
        err       = (err_raw > 13'sd2047)  ? 12'sh7FF :
                    (err_raw < -13'sd2048) ? 12'sh800 : err_raw[11:0];
        flush     = {lft_opn, rght_opn} != opn_q;
        old       = buf_q[ptr];
        ptr_nxt   = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        sum_nxt   = sum + SW'(err) - SW'(old);
        sum_fl    = SW'(err) <<< AVG_LOG;
        avg_nxt   = 12'(sum_nxt >>> AVG_LOG);
        cnt_inc   = cnt + 8'd1;
        evt       = !flush && (cnt_inc == 8'(D_PERIOD));
        // Derivative is the change of the filtered error across one event period.
        diff      = 13'(avg_nxt) - 13'(snap);
        d9        = (diff > 13'sd255)  ? 9'h0FF :
                    (diff < -13'sd256) ? 9'h100 : diff[8:0];
        dterm_nxt = DW'(d9) <<< D_SHFT;
    end

    always_comb begin
        avg_q   = 12'(sum >>> AVG_LOG);
        p_term  = avg_q >>> P_SHFT;
        csum    = 13'(p_term) + 13'(dterm);
        corr    = csum >>> 1;
        s14     = 14'($signed(dsrd_hdng)) + 14'(corr);
        clipped = (s14 > 14'sd2047) || (s14 < -14'sd2048);
        clip    = (s14 > 14'sd2047)  ? 12'sh7FF :
                  (s14 < -14'sd2048) ? 12'sh800 : s14[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            ptr           <= '0;
            sum           <= '0;
            cnt           <= '0;
            snap          <= '0;
            primed        <= 1'b0;
            dterm         <= '0;
            opn_q         <= 2'b00;
            s1_vld        <= 1'b0;
            adj_vld       <= 1'b0;
            dsrd_hdng_adj <= '0;
            sat           <= 1'b0;
        end else begin
            s1_vld  <= vld;
            adj_vld <= s1_vld;
            if (vld) begin
                opn_q <= {lft_opn, rght_opn};
                if (flush) begin
                    for (int i = 0; i < DEPTH; i++) buf_q[i] <= err;
                    sum    <= sum_fl;
                    ptr    <= '0;
                    cnt    <= '0;
                    primed <= 1'b0;
                    dterm  <= '0;
                end else begin
                    buf_q[ptr] <= err;
                    ptr        <= ptr_nxt;
                    sum        <= sum_nxt;
                    cnt        <= evt ? 8'd0 : cnt_inc;
                    if (evt) begin
                        if (primed) dterm <= dterm_nxt;
                        snap   <= avg_nxt;
                        primed <= 1'b1;
                    end
                end
            end
            if (s1_vld) begin
                dsrd_hdng_adj <= en_fusion ? clip : dsrd_hdng;
                sat           <= en_fusion && clipped;
            end
        end
    end
endmodule

// File: tb/tb_ir_hdng_fuse.sv
// tb_ir_hdng_fuse: directed and random stimulus checked against an integer/queue reference model.
module tb_ir_hdng_fuse;
    logic        clk = 0, rst_n = 0, vld = 0, lft_opn = 0, rght_opn = 0, en_fusion = 0;
    logic [11:0] lft_IR = 0, rght_IR = 0, dsrd_hdng = 0;
    logic [11:0] dsrd_hdng_adj;
    logic        adj_vld, sat;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ir_hdng_fuse dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .lft_opn(lft_opn), .rght_opn(rght_opn),
        .lft_IR(lft_IR), .rght_IR(rght_IR), .en_fusion(en_fusion), .dsrd_hdng(dsrd_hdng),
        .dsrd_hdng_adj(dsrd_hdng_adj), .adj_vld(adj_vld), .sat(sat)
    );

    // Reference state: the averaging window is a plain FIFO of the last four errors.
    int q[$];
    int prev_pair, cnt, snap, dterm, pend_corr, exp_out;
    bit primed, pend_v, exp_sat, exp_adj;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_reset();
        q.delete();
        repeat (4) q.push_back(0);
        prev_pair = 0; cnt = 0; snap = 0; dterm = 0; pend_corr = 0; exp_out = 0;
        primed = 0; pend_v = 0; exp_sat = 0; exp_adj = 0;
    endtask

    task automatic model_edge();
        int s, l, r, e, pair, avg, tot;
        if (pend_v) begin
            s = $signed(dsrd_hdng) + pend_corr;
            if (en_fusion) begin
                exp_out = clamp(s, -2048, 2047);
                exp_sat = (exp_out != s);
            end else begin
                exp_out = $signed(dsrd_hdng);
                exp_sat = 0;
            end
        end
        exp_adj = pend_v;
        pend_v  = vld;
        if (vld) begin
            l = lft_IR; r = rght_IR; pair = {lft_opn, rght_opn};
            e = (lft_opn && rght_opn) ? 0 : lft_opn ? 2416 - r : rght_opn ? l - 2416 : (l - r) >>> 1;
            e = clamp(e, -2048, 2047);
            if (pair != prev_pair) begin
                foreach (q[i]) q[i] = e;
                cnt = 0; primed = 0; dterm = 0;
            end else begin
                void'(q.pop_front());
                q.push_back(e);
                cnt++;
            end
            tot = 0;
            foreach (q[i]) tot += q[i];
            avg = tot >>> 2;
            if (pair == prev_pair && cnt == 4) begin
                cnt = 0;
                if (primed) dterm = clamp(avg - snap, -256, 255) * 4;
                snap = avg; primed = 1;
            end
            prev_pair = pair;
            pend_corr = ((avg >>> 5) + dterm) >>> 1;
        end
    endtask

    task automatic cyc(bit v, bit lo, bit ro, int l, int r, bit en, int d);
        vld = v; lft_opn = lo; rght_opn = ro; lft_IR = 12'(l); rght_IR = 12'(r);
        en_fusion = en; dsrd_hdng = 12'(d);
        model_edge();
        @(negedge clk);
        check("adj_vld", int'(adj_vld), int'(exp_adj));
        check("adj", $signed(dsrd_hdng_adj), exp_out);
        check("sat", int'(sat), int'(exp_sat));
    endtask

    initial begin
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_adj", $signed(dsrd_hdng_adj), 0);
        check("rst_vld", int'(adj_vld), 0);
        check("rst_sat", int'(sat), 0);
        rst_n = 1;

        repeat (12) cyc(1, 0, 0, 'hA00, 'h900, 1, 'h100);
        repeat (2) cyc(0, 0, 0, 'hA00, 'h900, 1, 'h100);
        check("steady_const", $signed(dsrd_hdng_adj), 'h102);

        cyc(1, 1, 0, 'h123, 'h870, 1, 'h100);
        repeat (2) cyc(0, 1, 0, 'h123, 'h870, 1, 'h100);
        check("lopen_const", $signed(dsrd_hdng_adj), 'h104);

        for (int k = 0; k < 16; k++) cyc(1, 0, 0, 'h400 + 'h80 * k, 'h400, 1, 'h000);

        repeat (12) cyc(1, 0, 0, 'hFFF, 'h000, 1, 'h7F0);
        repeat (2) cyc(0, 0, 0, 'hFFF, 'h000, 1, 'h7F0);
        check("satp_const", $signed(dsrd_hdng_adj), 2047);
        check("satp_flag", int'(sat), 1);
        repeat (12) cyc(1, 0, 0, 'h000, 'hFFF, 1, 'h800);
        repeat (2) cyc(0, 0, 0, 'h000, 'hFFF, 1, 'h800);
        check("satn_const", $signed(dsrd_hdng_adj), -2048);
        check("satn_flag", int'(sat), 1);

        repeat (12) cyc(1, 0, 0, 'hA00, 'h900, 0, 'h123);
        repeat (2) cyc(0, 0, 0, 'hA00, 'h900, 0, 'h123);
        cyc(1, 0, 0, 'hA00, 'h900, 0, 'h123);
        check("byp_lat1", int'(adj_vld), 0);
        cyc(0, 0, 0, 'hA00, 'h900, 0, 'h123);
        check("byp_lat2", int'(adj_vld), 1);
        check("byp_const", $signed(dsrd_hdng_adj), 'h123);
        check("byp_sat", int'(sat), 0);
        cyc(1, 0, 0, 'hA00, 'h900, 1, 'h100);
        cyc(0, 0, 0, 'hA00, 'h900, 1, 'h100);
        check("reen_const", $signed(dsrd_hdng_adj), 'h102);

        cyc(1, 0, 1, 'hB00, 'h555, 1, 'h200);
        vld = 0;
        rst_n = 0;
        #1;
        check("mid_rst_adj", $signed(dsrd_hdng_adj), 0);
        check("mid_rst_sat", int'(sat), 0);
        model_reset();
        @(negedge clk);
        check("mid_rst_vld", int'(adj_vld), 0);
        rst_n = 1;
        repeat (10) cyc(1, 0, 0, 'hA00, 'h900, 1, 'h100);

        for (int n = 0; n < 1500; n++) begin
            bit lo, ro, en;
            int d;
            lo = ($urandom_range(0, 15) == 0) ? ~lft_opn : lft_opn;
            ro = ($urandom_range(0, 15) == 0) ? ~rght_opn : rght_opn;
            en = $urandom_range(0, 3) != 0;
            d  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 'h7E0 + $urandom_range(0, 31) : 'h800 + $urandom_range(0, 31))
                                             : $urandom_range(0, 4095);
            cyc($urandom_range(0, 3) != 0, lo, ro, $urandom_range(0, 4095), $urandom_range(0, 4095), en, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
